// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared control bundle, register/ALU constants and operand helpers for the ID/EX slice
package id_ex_stage_pkg;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_op;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_RTYPE = 3'd2;
  localparam logic [2:0] ALU_OR = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  function automatic logic is_load(input ctrl_t c);
    return c.mem_read;
  endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side operands/control in, EX-side registered operands and hazard outputs back
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W = 16
);
  import id_ex_stage_pkg::*;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_uses_rt;
  logic [DATA_W-1:0] id_rdata1;
  logic [DATA_W-1:0] id_rdata2;
  logic [DATA_W-1:0] id_imm;
  ctrl_t             id_ctrl;
  logic              flush;
  logic              ex_valid;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_dest;
  logic [DATA_W-1:0] ex_rdata1;
  logic [DATA_W-1:0] ex_rdata2;
  logic [DATA_W-1:0] ex_imm;
  ctrl_t             ex_ctrl;
  logic              stall;
  logic              pc_write;
  logic              if_id_write;
  logic [CNT_W-1:0]  stall_cnt;
  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_rdata1, id_rdata2, id_imm, id_ctrl, flush,
    input  ex_valid, ex_rs, ex_rt, ex_dest, ex_rdata1, ex_rdata2, ex_imm, ex_ctrl,
    input  stall, pc_write, if_id_write, stall_cnt
  );
  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_rdata1, id_rdata2, id_imm, id_ctrl, flush,
    output ex_valid, ex_rs, ex_rt, ex_dest, ex_rdata1, ex_rdata2, ex_imm, ex_ctrl,
    output stall, pc_write, if_id_write, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the nonzero target of a load currently in EX
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  output logic              hz_o
);
  logic ex_load;
  logic reads_target;
  assign ex_load = ex_valid_i & ex_mem_read_i & (ex_rt_i != '0);
  assign reads_target = (ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i));
  assign hz_o = id_valid_i & ex_load & reads_target;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion, branch flush and stall counting
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  id_ex_stage_if.slave  bus
);
  logic              valid_q, valid_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [DATA_W-1:0] rdata2_q, rdata2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hz;
  logic              stall;
  logic              bubble;
  load_use_detect #(.REG_AW(REG_AW)) u_hz (
    .id_valid_i   (bus.id_valid),
    .id_rs_i      (bus.id_rs),
    .id_rt_i      (bus.id_rt),
    .id_uses_rt_i (bus.id_uses_rt),
    .ex_valid_i   (valid_q),
    .ex_mem_read_i(is_load(ctrl_q)),
    .ex_rt_i      (rt_q),
    .hz_o         (hz)
  );
  // a flush squashes IF/ID anyway, so it suppresses the stall request
  assign stall = hz & ~bus.flush;
  assign bubble = bus.flush | stall;
  // next EX contents: a bubble on flush or load-use, otherwise the ID instruction
  always_comb begin
    valid_d = bubble ? 1'b0 : bus.id_valid;
    rs_d = bubble ? '0 : bus.id_rs;
    rt_d = bubble ? '0 : bus.id_rt;
    dest_d = bubble ? '0 : (bus.id_ctrl.reg_dst ? bus.id_rd : bus.id_rt);
    rdata1_d = bubble ? '0 : bus.id_rdata1;
    rdata2_d = bubble ? '0 : bus.id_rdata2;
    imm_d = bubble ? '0 : bus.id_imm;
    ctrl_d = bubble ? CTRL_NOP : bus.id_ctrl;
    cnt_d = (stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // pipeline register bank and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rs_q <= '0;
      rt_q <= '0;
      dest_q <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q <= '0;
      ctrl_q <= CTRL_NOP;
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      rs_q <= rs_d;
      rt_q <= rt_d;
      dest_q <= dest_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q <= imm_d;
      ctrl_q <= ctrl_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.ex_valid = valid_q;
  assign bus.ex_rs = rs_q;
  assign bus.ex_rt = rt_q;
  assign bus.ex_dest = dest_q;
  assign bus.ex_rdata1 = rdata1_q;
  assign bus.ex_rdata2 = rdata2_q;
  assign bus.ex_imm = imm_q;
  assign bus.ex_ctrl = ctrl_q;
  assign bus.stall = stall;
  assign bus.pc_write = ~stall;
  assign bus.if_id_write = ~stall;
  assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table, reset sequences and randomized model check for id_ex_stage
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  id_ex_stage_if a();
  id_ex_stage_if #(.CNT_W(3)) b();
  id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(a));
  id_ex_stage #(.CNT_W(3)) dut_s (.clk(clk), .rst_n(rst_n), .bus(b));
  assign b.id_valid = a.id_valid;
  assign b.id_rs = a.id_rs;
  assign b.id_rt = a.id_rt;
  assign b.id_rd = a.id_rd;
  assign b.id_uses_rt = a.id_uses_rt;
  assign b.id_rdata1 = a.id_rdata1;
  assign b.id_rdata2 = a.id_rdata2;
  assign b.id_imm = a.id_imm;
  assign b.id_ctrl = a.id_ctrl;
  assign b.flush = a.flush;
  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic        ut, mr, rdst, fl, st, exv;
    logic [4:0]  ers, ert, edst;
    logic [15:0] ecnt;
  } vec_t;
  typedef struct {
    logic        v;
    logic [4:0]  rs, rt, dest;
    logic [31:0] d1, d2, imm;
    ctrl_t       c;
  } ex_t;
  vec_t tbl[20];
  ex_t m;
  int unsigned mcnt;
  int n_tests = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input int rs, rt, rd, ut, mr, rdst, fl, st, exv, ers, ert, edst, ecnt);
    mk.rs = 5'(rs); mk.rt = 5'(rt); mk.rd = 5'(rd);
    mk.ut = ut != 0; mk.mr = mr != 0; mk.rdst = rdst != 0; mk.fl = fl != 0;
    mk.st = st != 0; mk.exv = exv != 0;
    mk.ers = 5'(ers); mk.ert = 5'(ert); mk.edst = 5'(edst); mk.ecnt = 16'(ecnt);
  endfunction
  function automatic ctrl_t mkc(input logic mr, input logic rdst);
    ctrl_t c;
    c = CTRL_NOP;
    c.reg_write = 1'b1;
    c.mem_read = mr;
    c.mem_to_reg = mr;
    c.alu_src = mr;
    c.reg_dst = rdst;
    c.alu_op = rdst ? ALU_RTYPE : ALU_ADD;
    return c;
  endfunction
  task automatic drive(input logic v, input logic [4:0] rs, rt, rd, input logic ut,
                       input logic [31:0] d1, d2, imm, input ctrl_t c, input logic fl);
    a.id_valid = v; a.id_rs = rs; a.id_rt = rt; a.id_rd = rd; a.id_uses_rt = ut;
    a.id_rdata1 = d1; a.id_rdata2 = d2; a.id_imm = imm; a.id_ctrl = c; a.flush = fl;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ex_valid"}, 32'(a.ex_valid), 0);
    chk({tag, "_ex_rs"}, 32'(a.ex_rs), 0);
    chk({tag, "_ex_rt"}, 32'(a.ex_rt), 0);
    chk({tag, "_ex_dest"}, 32'(a.ex_dest), 0);
    chk({tag, "_ex_rdata1"}, a.ex_rdata1, 0);
    chk({tag, "_ex_rdata2"}, a.ex_rdata2, 0);
    chk({tag, "_ex_imm"}, a.ex_imm, 0);
    chk({tag, "_ex_ctrl"}, 32'(a.ex_ctrl), 0);
    chk({tag, "_stall"}, 32'(a.stall), 0);
    chk({tag, "_pc_write"}, 32'(a.pc_write), 1);
    chk({tag, "_stall_cnt"}, 32'(a.stall_cnt), 0);
  endtask
  task automatic chk_model();
    chk("rnd_ex_valid", 32'(a.ex_valid), 32'(m.v));
    chk("rnd_ex_rs", 32'(a.ex_rs), 32'(m.rs));
    chk("rnd_ex_rt", 32'(a.ex_rt), 32'(m.rt));
    chk("rnd_ex_dest", 32'(a.ex_dest), 32'(m.dest));
    chk("rnd_ex_rdata1", a.ex_rdata1, m.d1);
    chk("rnd_ex_rdata2", a.ex_rdata2, m.d2);
    chk("rnd_ex_imm", a.ex_imm, m.imm);
    chk("rnd_ex_ctrl", 32'(a.ex_ctrl), 32'(m.c));
    chk("rnd_stall_cnt", 32'(a.stall_cnt), mcnt > 65535 ? 65535 : mcnt);
    chk("rnd_stall_cnt_sat3", 32'(b.stall_cnt), mcnt > 7 ? 7 : mcnt);
  endtask
  initial begin
    tbl[0]  = mk(1, 2, 3, 1, 0, 1, 0, 0, 1, 1, 2, 3, 0);
    tbl[1]  = mk(1, 5, 0, 0, 1, 0, 0, 0, 1, 1, 5, 5, 0);
    tbl[2]  = mk(5, 2, 6, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1);
    tbl[3]  = mk(5, 2, 6, 1, 0, 1, 0, 0, 1, 5, 2, 6, 1);
    tbl[4]  = mk(1, 5, 0, 0, 1, 0, 0, 0, 1, 1, 5, 5, 1);
    tbl[5]  = mk(7, 8, 6, 1, 0, 1, 0, 0, 1, 7, 8, 6, 1);
    tbl[6]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 1);
    tbl[7]  = mk(0, 0, 4, 1, 0, 1, 0, 0, 1, 0, 0, 4, 1);
    tbl[8]  = mk(1, 5, 0, 0, 1, 0, 0, 0, 1, 1, 5, 5, 1);
    tbl[9]  = mk(4, 5, 0, 0, 0, 0, 0, 0, 1, 4, 5, 5, 1);
    tbl[10] = mk(1, 5, 0, 0, 1, 0, 0, 0, 1, 1, 5, 5, 1);
    tbl[11] = mk(5, 2, 6, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    tbl[12] = mk(5, 2, 6, 1, 0, 1, 0, 0, 1, 5, 2, 6, 1);
    tbl[13] = mk(1, 7, 0, 0, 1, 0, 0, 0, 1, 1, 7, 7, 1);
    tbl[14] = mk(2, 7, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2);
    tbl[15] = mk(2, 7, 0, 1, 0, 0, 0, 0, 1, 2, 7, 7, 2);
    tbl[16] = mk(1, 5, 0, 0, 1, 0, 0, 0, 1, 1, 5, 5, 2);
    tbl[17] = mk(5, 6, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 3);
    tbl[18] = mk(5, 6, 0, 0, 1, 0, 0, 0, 1, 5, 6, 6, 3);
    tbl[19] = mk(1, 2, 7, 1, 0, 1, 0, 0, 1, 1, 2, 7, 3);
    // reset held with busy inputs, then a load-use stall interrupted by an async reset
    drive(1, 1, 5, 0, 0, 32'hAAAA, 32'hBBBB, 32'h4, mkc(1, 0), 0);
    #1;
    chk("rst_hold_stall", 32'(a.stall), 0);
    chk("rst_hold_valid", 32'(a.ex_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("pre_lw_valid", 32'(a.ex_valid), 1);
    chk("pre_lw_dest", 32'(a.ex_dest), 5);
    @(negedge clk);
    drive(1, 5, 2, 6, 1, 32'h11, 32'h22, 32'h0, mkc(0, 1), 0);
    #1;
    chk("pre_stall", 32'(a.stall), 1);
    @(posedge clk); #1;
    chk("pre_cnt", 32'(a.stall_cnt), 1);
    @(negedge clk);
    drive(1, 1, 5, 0, 0, 32'hAAAA, 32'hBBBB, 32'h4, mkc(1, 0), 0);
    @(negedge clk);
    drive(1, 5, 2, 6, 1, 32'h11, 32'h22, 32'h0, mkc(0, 1), 0);
    #1;
    chk("mid_stall", 32'(a.stall), 1);
    #1 rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_stall", 32'(a.stall), 0);
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(a.ex_valid), 1);
    chk("post_rst_dest", 32'(a.ex_dest), 6);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // directed vectors: pass-through, load-use, r0, rt-only, flush+hazard, back-to-back loads
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].ut, 32'h1000 + 32'(i), 32'h2000 + 32'(i),
            32'(i), mkc(tbl[i].mr, tbl[i].rdst), tbl[i].fl);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(a.stall), 32'(tbl[i].st));
      chk($sformatf("v%0d_pc_write", i), 32'(a.pc_write), 32'(!tbl[i].st));
      chk($sformatf("v%0d_if_id_write", i), 32'(a.if_id_write), 32'(!tbl[i].st));
      @(posedge clk); #1;
      chk($sformatf("v%0d_ex_valid", i), 32'(a.ex_valid), 32'(tbl[i].exv));
      chk($sformatf("v%0d_ex_rs", i), 32'(a.ex_rs), 32'(tbl[i].ers));
      chk($sformatf("v%0d_ex_rt", i), 32'(a.ex_rt), 32'(tbl[i].ert));
      chk($sformatf("v%0d_ex_dest", i), 32'(a.ex_dest), 32'(tbl[i].edst));
      chk($sformatf("v%0d_stall_cnt", i), 32'(a.stall_cnt), 32'(tbl[i].ecnt));
      chk($sformatf("v%0d_reg_write", i), 32'(a.ex_ctrl.reg_write), 32'(tbl[i].exv));
      chk($sformatf("v%0d_rdata1", i), a.ex_rdata1, tbl[i].exv ? 32'h1000 + 32'(i) : 32'h0);
    end
    // randomized traffic against the reference model, small register range to provoke hazards
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m = '{v: 1'b0, rs: '0, rt: '0, dest: '0, d1: '0, d2: '0, imm: '0, c: CTRL_NOP};
    mcnt = 0;
    for (int i = 0; i < 3000; i++) begin
      logic v, ut, fl, ld_in_ex, reads, exp_stall;
      logic [4:0] rs, rt, rd;
      logic [31:0] d1, d2, imm;
      ctrl_t c;
      @(negedge clk);
      v = $urandom_range(0, 7) != 0;
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      ut = 1'($urandom);
      fl = $urandom_range(0, 9) == 0;
      d1 = $urandom; d2 = $urandom; imm = $urandom;
      c = ctrl_t'(9'($urandom));
      drive(v, rs, rt, rd, ut, d1, d2, imm, c, fl);
      #1;
      ld_in_ex = m.v && m.c.mem_read && m.rt != 5'd0;
      reads = (m.rt == rs) || (ut && m.rt == rt);
      exp_stall = v && ld_in_ex && reads && !fl;
      chk("rnd_stall", 32'(a.stall), 32'(exp_stall));
      chk("rnd_pc_write", 32'(a.pc_write), 32'(!exp_stall));
      chk("rnd_if_id_write", 32'(a.if_id_write), 32'(!exp_stall));
      @(posedge clk);
      if (fl || exp_stall)
        m = '{v: 1'b0, rs: '0, rt: '0, dest: '0, d1: '0, d2: '0, imm: '0, c: CTRL_NOP};
      else
        m = '{v: v, rs: rs, rt: rt, dest: c.reg_dst ? rd : rt, d1: d1, d2: d2, imm: imm, c: c};
      if (exp_stall) mcnt++;
      #1;
      chk_model();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
